hazard_controller: RTL and testbench

- Pipeline-control counterpart to the forwarding logic of the 5-stage MIPS core.
- Forwarding consumes EX/MEM/WB results to repair data hazards. This block produces the stall, flush and enable controls for every pipeline latch and the PC when forwarding cannot cover a hazard: load-use, PC redirect, cache miss, and halt drain.
- Owns a small wait/halt FSM and saturating performance counters.

---
 rtl/hazard_controller.sv | 178 +++++++++++++++++
 tb/tb_hazard_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
`timescale 1ns/1ps
// hazard_controller
//   Stall / flush / enable generation for the 5-stage pipeline latches and
//   the PC when forwarding cannot resolve a hazard (load-use, EX redirect,
//   icache miss, dcache wait, halt drain). Owns the RUN/DWAIT/HALT FSM and
//   saturating stall/flush performance counters.
// Ports:
//   CLK, RST          clock (rising edge), async active-high reset
//   ihit, dhit        icache / dcache completion this cycle
//   mem_dREN/dWEN     MEM-stage load / store request
//   id_instr          instruction in ID (rs/rt/opcode decode)
//   ex_memREN/ex_dest EX-stage load flag and destination register
//   ex_redirect       taken branch / jump resolved in EX
//   wb_halt           HALT instruction in WB
//   pc_en, *_en       PC and latch enables
//   *_flush           bubble insertion into the next latch
//   halt              sticky halted flag
//   dwait_timeout     sticky dcache wait overrun flag
//   stall_cycles      cycles with pc_en=0 outside HALT (saturating)
//   flush_events      accepted redirects (saturating)
module hazard_controller #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic [31:0]      id_instr,
  input  logic             ex_memREN,
  input  logic [4:0]       ex_dest,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic             dwait_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned WCNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WLIM = WCNT_W'(WAIT_LIMIT);

  typedef enum logic [1:0] {S_RUN, S_DWAIT, S_HALT} state_e;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               dwait_timeout_q, dwait_timeout_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]   flush_events_q, flush_events_d;

  logic        dreq, dstall, uses_rt, loaduse, redirect_ok;
  logic [4:0]  rs, rt;
  logic [5:0]  opcode;
  logic [WCNT_W-1:0] wait_inc;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^id_instr[15:0];

  always_comb begin
    dreq    = mem_dREN | mem_dWEN;
    dstall  = dreq & ~dhit;
    opcode  = id_instr[31:26];
    rs      = id_instr[25:21];
    rt      = id_instr[20:16];
    uses_rt = (opcode == 6'h00) | (opcode == 6'h04) | (opcode == 6'h05) | (opcode == 6'h2B);
    loaduse = ex_memREN & (ex_dest != 5'd0) & ((ex_dest == rs) | (uses_rt & (ex_dest == rt)));
  end

  // Pipeline control: priority dmem stall > redirect > load-use > icache miss.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    redirect_ok = 1'b0;
    if (!RST && state_q != S_HALT) begin
      if (dstall) begin
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
      end else if (ex_redirect) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        redirect_ok = 1'b1;
      end else if (loaduse) begin
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end else if (!ihit) begin
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end else begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (dstall) state_d = S_DWAIT;
      S_DWAIT: if (dhit)   state_d = S_RUN;
      default: state_d = S_HALT;
    endcase
    if (wb_halt) state_d = S_HALT;
  end

  // wait_cnt saturates at the limit; the timeout flag is evaluated on the
  // incremented value so it rises in the cycle the limit is reached.
  always_comb begin
    wait_inc        = (wait_cnt_q == WLIM) ? wait_cnt_q : wait_cnt_q + WCNT_W'(1);
    dwait_timeout_d = dwait_timeout_q;
    wait_cnt_d      = '0;
    if (state_q == S_DWAIT && !dhit) begin
      if (wait_inc == WLIM) dwait_timeout_d = 1'b1;
      if (state_d == S_DWAIT) wait_cnt_d = wait_inc;
    end else if (state_d == S_DWAIT) begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (state_q != S_HALT && !pc_en && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (redirect_ok && flush_events_q != '1)
      flush_events_d = flush_events_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= S_RUN;
      wait_cnt_q      <= '0;
      dwait_timeout_q <= 1'b0;
      stall_cycles_q  <= '0;
      flush_events_q  <= '0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      dwait_timeout_q <= dwait_timeout_d;
      stall_cycles_q  <= stall_cycles_d;
      flush_events_q  <= flush_events_d;
    end
  end

  assign halt          = (state_q == S_HALT);
  assign dwait_timeout = dwait_timeout_q;
  assign stall_cycles  = stall_cycles_q;
  assign flush_events  = flush_events_q;

endmodule

// File: tb/tb_hazard_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for hazard_controller: a stimulus process drives inputs
// and pushes the reference model's expected outputs; a monitor pops and
// compares at every falling edge.
module tb_hazard_controller;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned WAIT_LIMIT = 4;
  localparam int          CMAX       = (1 << CNT_W) - 1;

  logic CLK, RST, ihit, dhit, mem_dREN, mem_dWEN, ex_memREN, ex_redirect, wb_halt;
  logic [31:0] id_instr;
  logic [4:0]  ex_dest;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_flush, halt, dwait_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  hazard_controller #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .id_instr(id_instr), .ex_memREN(ex_memREN),
    .ex_dest(ex_dest), .ex_redirect(ex_redirect), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .halt(halt), .dwait_timeout(dwait_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, memwb_flush, halt, dwait_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_tag = "init";

  // Reference model state, in plain terms.
  bit m_halted, m_waiting, m_timeout;
  int m_waited, m_stalls, m_flushes;

  function automatic void model_reset();
    m_halted = 0; m_waiting = 0; m_timeout = 0;
    m_waited = 0; m_stalls = 0; m_flushes = 0;
  endfunction

  function automatic obs_t model_expect();
    obs_t e = '0;
    bit dreq, lu, rt_used;
    logic [5:0] op;
    if (RST) return e;
    e.stall_cycles  = CNT_W'(m_stalls);
    e.flush_events  = CNT_W'(m_flushes);
    e.dwait_timeout = m_timeout;
    if (m_halted) begin
      e.halt = 1'b1;
      return e;
    end
    dreq    = mem_dREN || mem_dWEN;
    op      = id_instr[31:26];
    rt_used = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'h2B);
    lu      = ex_memREN && ex_dest != 0 &&
              (ex_dest == id_instr[25:21] || (rt_used && ex_dest == id_instr[20:16]));
    if (dreq && !dhit) begin
      e.memwb_en = 1; e.memwb_flush = 1;
    end else if (ex_redirect) begin
      {e.pc_en, e.ifid_en, e.idex_en, e.exmem_en, e.memwb_en} = '1;
      e.ifid_flush = 1; e.idex_flush = 1;
    end else if (lu) begin
      e.idex_en = 1; e.idex_flush = 1; e.exmem_en = 1; e.memwb_en = 1;
    end else if (!ihit) begin
      e.ifid_en = 1; e.ifid_flush = 1; e.idex_en = 1; e.exmem_en = 1; e.memwb_en = 1;
    end else begin
      {e.pc_en, e.ifid_en, e.idex_en, e.exmem_en, e.memwb_en} = '1;
    end
    return e;
  endfunction

  function automatic void model_step(input obs_t e);
    bit dreq;
    if (RST) begin model_reset(); return; end
    if (m_halted) return;
    dreq = mem_dREN || mem_dWEN;
    if (!e.pc_en && m_stalls < CMAX) m_stalls++;
    if (ex_redirect && !(dreq && !dhit) && m_flushes < CMAX) m_flushes++;
    if (m_waiting && !dhit) begin
      m_waited++;
      if (m_waited >= WAIT_LIMIT) m_timeout = 1;
    end
    if (wb_halt) begin
      m_halted = 1; m_waiting = 0; m_waited = 0;
    end else if (m_waiting) begin
      if (dhit) begin m_waiting = 0; m_waited = 0; end
    end else if (dreq && !dhit) begin
      m_waiting = 1;
    end
  endfunction

  task automatic idle_inputs();
    RST = 0; ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0;
    id_instr = 32'd0; ex_memREN = 0; ex_dest = 5'd0; ex_redirect = 0; wb_halt = 0;
  endtask

  // Inputs are already driven; compute and queue expectation, then advance.
  task automatic tick();
    obs_t e;
    if (RST) model_reset();
    e = model_expect();
    exp_q.push_back(e);
    tag_q.push_back(cur_tag);
    @(posedge CLK);
    model_step(e);
    #1;
  endtask

  always @(negedge CLK) begin
    obs_t got, want;
    string t;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      got  = '{pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               memwb_flush, halt, dwait_timeout, stall_cycles, flush_events};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s @%0t: got pc/ifid/idex/exmem/memwb=%b%b%b%b%b fl=%b%b%b halt=%b to=%b st=%0d fe=%0d, want %b%b%b%b%b fl=%b%b%b halt=%b to=%b st=%0d fe=%0d",
          t, $time, got.pc_en, got.ifid_en, got.idex_en, got.exmem_en, got.memwb_en,
          got.ifid_flush, got.idex_flush, got.memwb_flush, got.halt, got.dwait_timeout,
          got.stall_cycles, got.flush_events,
          want.pc_en, want.ifid_en, want.idex_en, want.exmem_en, want.memwb_en,
          want.ifid_flush, want.idex_flush, want.memwb_flush, want.halt, want.dwait_timeout,
          want.stall_cycles, want.flush_events);
      end
    end
  end

  localparam logic [31:0] ADDU_3_5_2 = {6'd0, 5'd5, 5'd2, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] ADDI_2_7   = {6'h08, 5'd7, 5'd2, 16'h0010};

  initial begin
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};
    model_reset();
    idle_inputs();
    RST = 1;
    @(posedge CLK); #1;

    cur_tag = "reset";      RST = 1; tick(); tick();
    cur_tag = "run_idle";   idle_inputs(); tick(); tick();

    cur_tag = "loaduse_rs"; ex_memREN = 1; ex_dest = 5'd5; id_instr = ADDU_3_5_2; tick();
    cur_tag = "loaduse_clr"; ex_memREN = 0; tick();
    cur_tag = "loaduse_rt"; ex_memREN = 1; ex_dest = 5'd2; tick();
    cur_tag = "loaduse_r0"; ex_dest = 5'd0; id_instr = {6'd0, 5'd0, 5'd0, 16'd0}; tick();
    cur_tag = "addi_no_rt"; ex_dest = 5'd2; id_instr = ADDI_2_7; tick();
    idle_inputs(); tick();

    cur_tag = "dmiss";      mem_dREN = 1; dhit = 0; tick(); tick(); tick();
    cur_tag = "dmiss_rel";  dhit = 1; tick();
    idle_inputs(); tick();

    cur_tag = "redir_imiss"; ex_redirect = 1; ihit = 0; tick();
    idle_inputs(); tick();

    cur_tag = "redir_dstall"; mem_dWEN = 1; ex_redirect = 1; tick(); tick();
    cur_tag = "redir_accept"; dhit = 1; tick();
    idle_inputs(); tick();

    cur_tag = "timeout";    mem_dREN = 1; repeat (6) tick();
    cur_tag = "timeout_rel"; dhit = 1; tick();
    cur_tag = "timeout_sticky"; idle_inputs(); tick(); tick();

    cur_tag = "rst_dwait";  mem_dREN = 1; tick(); tick();
    RST = 1; tick();
    cur_tag = "after_rst";  idle_inputs(); tick(); tick();

    cur_tag = "halt_lu";    ex_memREN = 1; ex_dest = 5'd5; id_instr = ADDU_3_5_2; wb_halt = 1; tick();
    cur_tag = "halted";     idle_inputs(); ihit = 0; mem_dREN = 1; ex_redirect = 1; repeat (3) tick();
    cur_tag = "halt_rst";   idle_inputs(); RST = 1; tick();
    idle_inputs(); tick();

    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      RST         = ($urandom_range(0, 99) == 0);
      ihit        = ($urandom_range(0, 3) != 0);
      dhit        = ($urandom_range(0, 2) != 0);
      mem_dREN    = ($urandom_range(0, 2) == 0);
      mem_dWEN    = ($urandom_range(0, 5) == 0);
      id_instr    = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 16'($urandom)};
      ex_memREN   = ($urandom_range(0, 1) == 1);
      ex_dest     = 5'($urandom_range(0, 7));
      ex_redirect = ($urandom_range(0, 4) == 0);
      wb_halt     = ($urandom_range(0, 599) == 0);
      tick();
    end

    idle_inputs();
    @(negedge CLK); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
